// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and load-type codes
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } ltype_e;

endpackage

// File: rtl/wb_stage_dual_if.sv
// rtl/wb_stage_dual_if.sv - memory-stage slots in, register-file write ports out
interface wb_stage_dual_if;
  import mips_pkg::*;

  logic            m_valid_1;
  logic            m_w_en_1;
  logic [4:0]      m_w_addr_1;
  logic [XLEN-1:0] m_alu_1;
  logic            m_load_1;
  logic [2:0]      m_ltype_1;
  logic [1:0]      m_addr_lo_1;
  logic [XLEN-1:0] m_rdata_1;

  logic            m_valid_2;
  logic            m_w_en_2;
  logic [4:0]      m_w_addr_2;
  logic [XLEN-1:0] m_alu_2;
  logic            m_load_2;
  logic [2:0]      m_ltype_2;
  logic [1:0]      m_addr_lo_2;
  logic [XLEN-1:0] m_rdata_2;

  logic            reg_w_en_1;
  logic [4:0]      reg_w_addr_1;
  logic [XLEN-1:0] reg_w_data_1;
  logic            reg_w_en_2;
  logic [4:0]      reg_w_addr_2;
  logic [XLEN-1:0] reg_w_data_2;

  modport master (
    output m_valid_1, m_w_en_1, m_w_addr_1, m_alu_1, m_load_1, m_ltype_1, m_addr_lo_1, m_rdata_1,
    output m_valid_2, m_w_en_2, m_w_addr_2, m_alu_2, m_load_2, m_ltype_2, m_addr_lo_2, m_rdata_2,
    input  reg_w_en_1, reg_w_addr_1, reg_w_data_1,
    input  reg_w_en_2, reg_w_addr_2, reg_w_data_2
  );

  modport slave (
    input  m_valid_1, m_w_en_1, m_w_addr_1, m_alu_1, m_load_1, m_ltype_1, m_addr_lo_1, m_rdata_1,
    input  m_valid_2, m_w_en_2, m_w_addr_2, m_alu_2, m_load_2, m_ltype_2, m_addr_lo_2, m_rdata_2,
    output reg_w_en_1, reg_w_addr_1, reg_w_data_1,
    output reg_w_en_2, reg_w_addr_2, reg_w_data_2
  );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the loaded byte/halfword from a raw memory word
module load_align
  import mips_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [2:0]      ltype,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [1:0]  byte_idx;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_idx = (BIG_ENDIAN != 0) ? (2'd3 - addr_lo) : addr_lo;
    case (byte_idx)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    // after mirroring, bit 1 of the byte index names the halfword in both byte orders
    sel_half = byte_idx[1] ? rdata[31:16] : rdata[15:0];

    case (ltype)
      LT_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  data = {24'd0, sel_byte};
      LT_LH:   data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  data = {16'd0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_dual.sv
// rtl/wb_stage_dual.sv - dual-issue MEM->WB register, load formatting, r0 suppression and retire count
module wb_stage_dual
  import mips_pkg::*;
#(
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  wb_stage_dual_if.slave   bus,
  output logic [CNT_W-1:0] retire_count
);

  logic [XLEN-1:0] ld_data_1, ld_data_2;
  logic [XLEN-1:0] w_data_1_d, w_data_2_d;
  logic            wr_1_raw, wr_2_raw, wr_1_d, wr_2_d;
  logic            valid_1_q, valid_2_q, wr_1_q, wr_2_q;

  load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align_1 (
    .ltype   (bus.m_ltype_1),
    .addr_lo (bus.m_addr_lo_1),
    .rdata   (bus.m_rdata_1),
    .data    (ld_data_1)
  );

  load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align_2 (
    .ltype   (bus.m_ltype_2),
    .addr_lo (bus.m_addr_lo_2),
    .rdata   (bus.m_rdata_2),
    .data    (ld_data_2)
  );

  always_comb begin
    w_data_1_d = bus.m_load_1 ? ld_data_1 : bus.m_alu_1;
    w_data_2_d = bus.m_load_2 ? ld_data_2 : bus.m_alu_2;
    wr_1_raw   = bus.m_valid_1 & bus.m_w_en_1 & (bus.m_w_addr_1 != REG_ZERO);
    wr_2_raw   = bus.m_valid_2 & bus.m_w_en_2 & (bus.m_w_addr_2 != REG_ZERO);
    // slot 2 is younger, so its write to a shared destination is the one that survives
    wr_1_d     = wr_1_raw & ~(wr_2_raw & (bus.m_w_addr_1 == bus.m_w_addr_2));
    wr_2_d     = wr_2_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_1_q        <= 1'b0;
      valid_2_q        <= 1'b0;
      wr_1_q           <= 1'b0;
      wr_2_q           <= 1'b0;
      bus.reg_w_addr_1 <= '0;
      bus.reg_w_addr_2 <= '0;
      bus.reg_w_data_1 <= '0;
      bus.reg_w_data_2 <= '0;
      retire_count     <= '0;
    end else if (flush) begin
      valid_1_q <= 1'b0;
      valid_2_q <= 1'b0;
    end else if (!stall) begin
      valid_1_q        <= bus.m_valid_1;
      valid_2_q        <= bus.m_valid_2;
      wr_1_q           <= wr_1_d;
      wr_2_q           <= wr_2_d;
      bus.reg_w_addr_1 <= bus.m_w_addr_1;
      bus.reg_w_addr_2 <= bus.m_w_addr_2;
      bus.reg_w_data_1 <= w_data_1_d;
      bus.reg_w_data_2 <= w_data_2_d;
      retire_count     <= retire_count + CNT_W'(bus.m_valid_1) + CNT_W'(bus.m_valid_2);
    end
  end

  // a flush clears only the valid flags, so the held write intent is masked here
  assign bus.reg_w_en_1 = valid_1_q & wr_1_q;
  assign bus.reg_w_en_2 = valid_2_q & wr_2_q;

endmodule

// File: tb/tb_wb_stage_dual.sv
// tb/tb_wb_stage_dual.sv - scoreboard bench for wb_stage_dual with a behavioural write-back model
module tb_wb_stage_dual;
  import mips_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] retire_count;

  wb_stage_dual_if bus ();

  wb_stage_dual #(.BIG_ENDIAN(0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .bus          (bus),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit        w_en;
    bit [4:0]  addr;
    bit [31:0] alu;
    bit        load;
    bit [2:0]  ltype;
    bit [1:0]  lo;
    bit [31:0] rdata;
  } slot_t;

  typedef struct {
    bit             en1;
    bit [4:0]       a1;
    bit [31:0]      d1;
    bit             en2;
    bit [4:0]       a2;
    bit [31:0]      d2;
    bit [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  model;
  exp_t  pend;
  bit    pending;
  int    tests = 0;
  int    fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic slot_t mk(bit valid, bit w_en, bit [4:0] addr, bit [31:0] alu,
                               bit load, bit [2:0] ltype, bit [1:0] lo, bit [31:0] rdata);
    slot_t s;
    s.valid = valid; s.w_en = w_en; s.addr = addr; s.alu = alu;
    s.load = load; s.ltype = ltype; s.lo = lo; s.rdata = rdata;
    return s;
  endfunction

  function automatic slot_t rand_slot();
    return mk(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 3'($urandom_range(0, 7)), 2'($urandom), $urandom);
  endfunction

  // little-endian load result from plain shifts and arithmetic extension
  function automatic bit [31:0] wb_value(slot_t s);
    bit [31:0] b, h;
    if (!s.load) return s.alu;
    b = (s.rdata >> (8 * s.lo)) & 32'hFF;
    h = (s.rdata >> (16 * (s.lo / 2))) & 32'hFFFF;
    case (s.ltype)
      3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return s.rdata;
    endcase
  endfunction

  task automatic drive(slot_t s1, slot_t s2);
    bus.m_valid_1 = s1.valid; bus.m_w_en_1 = s1.w_en; bus.m_w_addr_1 = s1.addr;
    bus.m_alu_1 = s1.alu; bus.m_load_1 = s1.load; bus.m_ltype_1 = s1.ltype;
    bus.m_addr_lo_1 = s1.lo; bus.m_rdata_1 = s1.rdata;
    bus.m_valid_2 = s2.valid; bus.m_w_en_2 = s2.w_en; bus.m_w_addr_2 = s2.addr;
    bus.m_alu_2 = s2.alu; bus.m_load_2 = s2.load; bus.m_ltype_2 = s2.ltype;
    bus.m_addr_lo_2 = s2.lo; bus.m_rdata_2 = s2.rdata;
  endtask

  task automatic step(bit st, bit fl, slot_t s1, slot_t s2);
    bit w1, w2;
    @(posedge clk); #1;
    if (pending) exp_q.push_back(pend);
    drive(s1, s2);
    stall = st;
    flush = fl;
    if (fl) begin
      model.en1 = 1'b0;
      model.en2 = 1'b0;
    end else if (!st) begin
      w1 = s1.valid && s1.w_en && (s1.addr != 0);
      w2 = s2.valid && s2.w_en && (s2.addr != 0);
      if (w1 && w2 && s1.addr == s2.addr) w1 = 1'b0;
      model.en1 = w1; model.a1 = s1.addr; model.d1 = wb_value(s1);
      model.en2 = w2; model.a2 = s2.addr; model.d2 = wb_value(s2);
      model.cnt = CNT_W'(int'(model.cnt) + int'(s1.valid) + int'(s2.valid));
    end
    pend    = model;
    pending = 1'b1;
  endtask

  // reset lands between edges, after a capture the scoreboard has not yet seen
  task automatic mid_reset();
    @(posedge clk); #1;
    pending = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_en1", bus.reg_w_en_1, 0);
    check("rst_en2", bus.reg_w_en_2, 0);
    check("rst_cnt", retire_count, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0));
    stall = 1'b0;
    flush = 1'b0;
    #1 reset = 1'b1;
    model   = '{default: '0};
    pend    = model;
    pending = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("en1",   bus.reg_w_en_1,   e.en1);
      check("addr1", bus.reg_w_addr_1, e.a1);
      check("data1", bus.reg_w_data_1, e.d1);
      check("en2",   bus.reg_w_en_2,   e.en2);
      check("addr2", bus.reg_w_addr_2, e.a2);
      check("data2", bus.reg_w_data_2, e.d2);
      check("count", retire_count,     e.cnt);
    end
  end

  initial begin
    slot_t idle, a, b;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    pending = 1'b0;
    model = '{default: '0};
    drive(idle, idle);
    repeat (2) @(posedge clk);
    #1;
    check("init_en1",   bus.reg_w_en_1,   0);
    check("init_en2",   bus.reg_w_en_2,   0);
    check("init_addr1", bus.reg_w_addr_1, 0);
    check("init_data2", bus.reg_w_data_2, 0);
    check("init_cnt",   retire_count,     0);
    reset = 1'b1;
    pend = model;
    pending = 1'b1;

    // load formatting on rdata 80F1_7F82
    step(0, 0, mk(1, 1, 1, 0, 1, 3'd1, 0, 32'h80F1_7F82), mk(1, 1, 2, 0, 1, 3'd2, 3, 32'h80F1_7F82));
    step(0, 0, mk(1, 1, 3, 0, 1, 3'd3, 2, 32'h80F1_7F82), mk(1, 1, 4, 0, 1, 3'd4, 0, 32'h80F1_7F82));
    step(0, 0, mk(1, 1, 5, 0, 1, 3'd0, 1, 32'h80F1_7F82), mk(1, 1, 6, 0, 1, 3'd7, 2, 32'h80F1_7F82));

    // same-destination conflict, then slot 2 not writing
    step(0, 0, mk(1, 1, 9, 11, 0, 0, 0, 0), mk(1, 1, 9, 22, 0, 0, 0, 0));
    step(0, 0, mk(1, 1, 9, 11, 0, 0, 0, 0), mk(1, 0, 9, 22, 0, 0, 0, 0));

    // r0 destination still retires
    step(0, 0, mk(1, 1, 0, 77, 0, 0, 0, 0), idle);
    step(0, 0, idle, mk(1, 1, 7, 33, 0, 0, 0, 0));

    // stall for three cycles with changing inputs, then stall+flush together
    step(0, 0, mk(1, 1, 12, 100, 0, 0, 0, 0), mk(1, 1, 13, 200, 0, 0, 0, 0));
    repeat (3) step(1, 0, rand_slot(), rand_slot());
    step(1, 1, rand_slot(), rand_slot());
    step(1, 0, rand_slot(), rand_slot());
    step(0, 0, rand_slot(), rand_slot());

    // reset in the middle of a stream of valid writes
    step(0, 0, mk(1, 1, 14, 5, 0, 0, 0, 0), mk(1, 1, 15, 6, 0, 0, 0, 0));
    mid_reset();

    // counter wrap: 9 dual-valid captures into a 4-bit counter
    for (int i = 0; i < 9; i++) begin
      a = rand_slot(); a.valid = 1'b1;
      b = rand_slot(); b.valid = 1'b1;
      step(0, 0, a, b);
    end
    step(1, 0, idle, idle);
    check("cnt_wrap", retire_count, 2);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, rand_slot(), rand_slot());
    step(0, 0, idle, idle);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
